// File: rtl/daq_rx_06.sv
// ALCT DAQ word-stream receiver: frames the 19-bit daqp stream, checks header, CRC-22,
// word count and trailer, and emits decoded header fields, LCT words and raw wire-group words.
module daq_rx_06 #(
  parameter int CONFIG_WORDS = 80,
  parameter int MAX_LCT_BINS = 15,
  parameter int MAX_RAW_BINS = 31
) (
  input  logic        clk,
  input  logic        hard_rst,
  input  logic [18:0] daqp,
  output logic [11:0] hdr_bxn,
  output logic [11:0] hdr_l1a_cnt,
  output logic [11:0] hdr_rd_cnt,
  output logic [3:0]  lct_bins,
  output logic [4:0]  raw_bins,
  output logic        lct_valid,
  output logic [11:0] lct_word,
  output logic        lct_first,
  output logic        raw_valid,
  output logic [4:0]  raw_tbin,
  output logic [2:0]  raw_layer,
  output logic [2:0]  raw_wg,
  output logic [11:0] raw_data,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [3:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_CFG, S_LCT, S_PAD, S_RAW, S_FILL, S_TRL} state_t;

  // CRC-22, polynomial x^22+x+1, data shifted in MSB first
  function automatic logic [21:0] crc22_step(input logic [21:0] c, input logic [15:0] d);
    logic [21:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[21] ^ d[i];
      r  = {r[20:0], 1'b0} ^ {20'd0, fb, fb};
    end
    return r;
  endfunction

  function automatic state_t sec_after(input logic cfg, input logic [3:0] lb, input logic [4:0] rb);
    if (cfg)            return S_CFG;
    else if (lb == 4'd1) return S_PAD;
    else if (lb != 4'd0) return S_LCT;
    else if (rb != 5'd0) return S_RAW;
    else                 return S_FILL;
  endfunction

  state_t      state_q;
  logic [6:0]  cnt_q;
  logic        cfg_q;
  logic [4:0]  tbin_q;
  logic [2:0]  layer_q;
  logic [2:0]  wg_q;
  logic [21:0] crc_q;
  logic [10:0] wcnt_q;

  logic [21:0] crc_d;
  logic [3:0]  err_d;
  logic [6:0]  lct_last;
  logic        last_tbin, is_tsup, is_lsup, layer_end, tbin_end, bins_bad;

  assign crc_d     = crc22_step(crc_q, daqp[15:0]);
  assign lct_last  = {2'b00, lct_bins - 4'd1, 1'b0} - 7'd1;
  assign last_tbin = (tbin_q == raw_bins - 5'd1);
  assign is_tsup   = (wg_q == 3'd0) && (daqp == 19'h02000);
  assign is_lsup   = (wg_q == 3'd0) && (daqp == 19'h01000);
  assign layer_end = is_lsup || (wg_q == 3'd7);
  assign tbin_end  = is_tsup || (layer_end && layer_q == 3'd5);
  assign bins_bad  = (32'(daqp[8:5]) > MAX_LCT_BINS) || (32'(daqp[4:0]) > MAX_RAW_BINS);

  // Error detected on the current word, highest-priority code only
  always_comb begin
    err_d = 4'd0;
    if (state_q != S_IDLE) begin
      if (daqp[18]) err_d = 4'd2;
      else begin
        case (state_q)
          S_HDR: begin
            if (cnt_q <= 7'd3 && daqp[15:12] != 4'hD)     err_d = 4'd1;
            else if (cnt_q == 7'd7 && daqp[14:9] != 6'h5)  err_d = 4'd1;
            else if (cnt_q == 7'd7 && bins_bad)            err_d = 4'd3;
          end
          S_PAD:  if (daqp[17:0] != 18'd0) err_d = 4'd4;
          S_FILL: if (daqp != 19'h03000 && (daqp != 19'h0DE0D || wcnt_q[1:0] != 2'd0)) err_d = 4'd6;
          S_TRL: begin
            if (cnt_q == 7'd0 && daqp[10:0] != crc_q[10:0])       err_d = 4'd5;
            else if (cnt_q == 7'd1 && daqp[10:0] != crc_q[21:11]) err_d = 4'd5;
            else if (cnt_q == 7'd2 && daqp[18:11] != 8'b00111010) err_d = 4'd4;
            else if (cnt_q == 7'd2 && daqp[10:0] != wcnt_q + 11'd1) err_d = 4'd6;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge hard_rst) begin
    if (!hard_rst) begin
      state_q <= S_IDLE;  cnt_q <= '0;  cfg_q <= 1'b0;
      tbin_q <= '0;  layer_q <= '0;  wg_q <= '0;  crc_q <= '0;  wcnt_q <= '0;
      hdr_bxn <= '0;  hdr_l1a_cnt <= '0;  hdr_rd_cnt <= '0;  lct_bins <= '0;  raw_bins <= '0;
      lct_valid <= 1'b0;  lct_word <= '0;  lct_first <= 1'b0;
      raw_valid <= 1'b0;  raw_tbin <= '0;  raw_layer <= '0;  raw_wg <= '0;  raw_data <= '0;
      frame_done <= 1'b0;  frame_ok <= 1'b0;  err_code <= '0;  frame_cnt <= '0;  err_cnt <= '0;
    end else begin
      lct_valid  <= 1'b0;
      raw_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (state_q == S_IDLE) begin
        if (!daqp[18] && daqp[15:0] == 16'hDB0A) begin
          state_q  <= S_HDR;
          cnt_q    <= 7'd1;
          crc_q    <= crc22_step(22'd0, daqp[15:0]);
          wcnt_q   <= 11'd1;
          err_code <= 4'd0;
          cfg_q    <= 1'b0;
          tbin_q   <= '0;
          layer_q  <= '0;
          wg_q     <= '0;
        end
      end else if (daqp[18]) begin
        // Idle inside a frame aborts it at once
        state_q    <= S_IDLE;
        frame_done <= 1'b1;
        frame_ok   <= 1'b0;
        if (err_code == 4'd0) err_code <= 4'd2;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else begin
        wcnt_q <= wcnt_q + 11'd1;
        if (err_code == 4'd0 && err_d != 4'd0) err_code <= err_d;
        if (state_q != S_TRL) crc_q <= crc_d;
        case (state_q)
          S_HDR: begin
            cnt_q <= cnt_q + 7'd1;
            case (cnt_q)
              7'd1: hdr_bxn     <= daqp[11:0];
              7'd2: hdr_l1a_cnt <= daqp[11:0];
              7'd3: hdr_rd_cnt  <= daqp[11:0];
              7'd4: cfg_q       <= daqp[14];
              7'd7: begin
                lct_bins <= daqp[8:5];
                raw_bins <= daqp[4:0];
                cnt_q    <= '0;
                state_q  <= sec_after(cfg_q, daqp[8:5], daqp[4:0]);
              end
              default: ;
            endcase
          end
          S_CFG: begin
            if (cnt_q == 7'(CONFIG_WORDS - 1)) begin
              cnt_q   <= '0;
              state_q <= sec_after(1'b0, lct_bins, raw_bins);
            end else cnt_q <= cnt_q + 7'd1;
          end
          S_LCT: begin
            lct_valid <= 1'b1;
            lct_word  <= daqp[11:0];
            lct_first <= ~cnt_q[0];
            if (cnt_q == lct_last) begin
              cnt_q   <= '0;
              state_q <= S_PAD;
            end else cnt_q <= cnt_q + 7'd1;
          end
          S_PAD: begin
            if (cnt_q == 7'd1) begin
              cnt_q   <= '0;
              state_q <= (raw_bins != 5'd0) ? S_RAW : S_FILL;
            end else cnt_q <= cnt_q + 7'd1;
          end
          S_RAW: begin
            if (!is_tsup) begin
              raw_valid <= 1'b1;
              raw_tbin  <= tbin_q;
              raw_layer <= layer_q;
              raw_wg    <= is_lsup ? 3'd0 : wg_q;
              raw_data  <= is_lsup ? 12'd0 : daqp[11:0];
            end
            if (tbin_end) begin
              wg_q    <= '0;
              layer_q <= '0;
              if (last_tbin) state_q <= S_FILL;
              else           tbin_q  <= tbin_q + 5'd1;
            end else if (layer_end) begin
              wg_q    <= '0;
              layer_q <= layer_q + 3'd1;
            end else wg_q <= wg_q + 3'd1;
          end
          S_FILL: begin
            // First non-filler word is taken as trailer word T0
            if (daqp != 19'h03000) begin
              cnt_q   <= '0;
              state_q <= S_TRL;
            end
          end
          S_TRL: begin
            if (cnt_q == 7'd2) begin
              state_q    <= S_IDLE;
              cnt_q      <= '0;
              frame_done <= 1'b1;
              frame_ok   <= (err_code == 4'd0) && (err_d == 4'd0);
              if (err_code == 4'd0 && err_d == 4'd0) begin
                if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
              end else if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else cnt_q <= cnt_q + 7'd1;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_daq_rx_06.sv
// Scoreboard bench for daq_rx_06: builds frames, queues expected LCT/raw/frame results, and
// compares them as the receiver produces output.
module tb_daq_rx_06;

  logic        clk = 1'b0;
  logic        hard_rst;
  logic [18:0] daqp;
  logic [11:0] hdr_bxn, hdr_l1a_cnt, hdr_rd_cnt;
  logic [3:0]  lct_bins;
  logic [4:0]  raw_bins;
  logic        lct_valid, lct_first, raw_valid, frame_done, frame_ok;
  logic [11:0] lct_word, raw_data;
  logic [4:0]  raw_tbin;
  logic [2:0]  raw_layer, raw_wg;
  logic [3:0]  err_code;
  logic [15:0] frame_cnt, err_cnt;

  daq_rx_06 dut (
    .clk(clk), .hard_rst(hard_rst), .daqp(daqp),
    .hdr_bxn(hdr_bxn), .hdr_l1a_cnt(hdr_l1a_cnt), .hdr_rd_cnt(hdr_rd_cnt),
    .lct_bins(lct_bins), .raw_bins(raw_bins),
    .lct_valid(lct_valid), .lct_word(lct_word), .lct_first(lct_first),
    .raw_valid(raw_valid), .raw_tbin(raw_tbin), .raw_layer(raw_layer), .raw_wg(raw_wg),
    .raw_data(raw_data), .frame_done(frame_done), .frame_ok(frame_ok), .err_code(err_code),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [18:0] IDLE_W = 19'h40000;

  typedef struct packed {
    logic        ok;
    logic [3:0]  err;
    logic [11:0] bxn;
  } fexp_t;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_fc  = 0;
  int exp_ec  = 0;

  fexp_t       exp_frm[$];
  logic [12:0] exp_lct[$];
  logic [22:0] exp_raw[$];
  logic [18:0] frm[$];
  logic [21:0] bcrc;
  bit          stop_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] crc_upd(input logic [21:0] c, input logic [15:0] d);
    logic [21:0] r;
    logic        fb;
    r = c;
    for (int i = 15; i >= 0; i--) begin
      fb = r[21] ^ d[i];
      r  = {r[20:0], 1'b0};
      if (fb) r = r ^ 22'h000003;
    end
    return r;
  endfunction

  task automatic put(input logic [18:0] clean, input logic [18:0] tx);
    frm.push_back(tx);
    bcrc = crc_upd(bcrc, clean[15:0]);
  endtask

  task automatic build(input logic [11:0] bxn, input bit cfg, input int lb, input int rb,
                       input int lsup, input int tsup_bin, input int tsup_layer,
                       input int flip_lct, input int idle_after, input bit bad_hdr);
    int          n;
    logic [11:0] d;
    logic [18:0] w, tx;
    logic [21:0] c;
    frm.delete();
    bcrc   = '0;
    n      = 0;
    stop_b = 0;
    put(19'h0DB0A, 19'h0DB0A);
    w = 19'h0D000 | 19'(bxn);                      put(w, w);
    w = (bad_hdr ? 19'h0C000 : 19'h0D000) | 19'h055; put(w, w);
    w = 19'h0D0AA;                                 put(w, w);
    w = cfg ? 19'h04000 : 19'h0;                   put(w, w);
    put(19'h0, 19'h0);
    put(19'h0, 19'h0);
    w = 19'(5 << 9) | 19'(lb << 5) | 19'(rb);      put(w, w);
    if (cfg) for (int i = 0; i < 80; i++) put(19'(i), 19'(i));
    if (lb > 0) begin
      for (int i = 0; i < 2 * (lb - 1); i++) begin
        d  = 12'($urandom);
        w  = 19'(d);
        tx = (i == flip_lct) ? (w ^ 19'h1) : w;
        put(w, tx);
        exp_lct.push_back({(i % 2 == 0) ? 1'b1 : 1'b0, tx[11:0]});
      end
      put(19'h0, 19'h0);
      put(19'h0, 19'h0);
    end
    for (int t = 0; t < rb && !stop_b; t++) begin
      for (int l = 0; l < 6 && !stop_b; l++) begin
        if (t == tsup_bin && l == tsup_layer) begin
          put(19'h02000, 19'h02000);
          break;
        end else if (l == lsup) begin
          put(19'h01000, 19'h01000);
          exp_raw.push_back({5'(t), 3'(l), 3'd0, 12'd0});
        end else begin
          for (int g = 0; g < 8 && !stop_b; g++) begin
            d = 12'($urandom);
            put(19'(d), 19'(d));
            exp_raw.push_back({5'(t), 3'(l), 3'(g), d});
            n++;
            if (n == idle_after) begin
              frm.push_back(IDLE_W);
              stop_b = 1;
            end
          end
        end
      end
    end
    if (!stop_b) begin
      while (frm.size() % 4 != 0) put(19'h03000, 19'h03000);
      put(19'h0DE0D, 19'h0DE0D);
      c = bcrc;
      frm.push_back(19'(c[10:0]));
      frm.push_back(19'(c[21:11]));
      frm.push_back({8'b00111010, 11'(frm.size() + 1)});
    end
  endtask

  task automatic drive(input logic [18:0] w);
    daqp = w;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int cut);
    for (int i = 0; i < frm.size() && i < cut; i++) drive(frm[i]);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) drive(IDLE_W);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_hdr"}, {hdr_bxn, hdr_l1a_cnt, lct_bins}, 32'd0);
    chk({tag, "_hdr2"}, {hdr_rd_cnt, raw_bins}, 32'd0);
    chk({tag, "_lct"}, {lct_valid, lct_first, lct_word}, 32'd0);
    chk({tag, "_raw"}, {raw_valid, raw_tbin, raw_layer, raw_wg, raw_data}, 32'd0);
    chk({tag, "_frm"}, {frame_done, frame_ok, err_code}, 32'd0);
    chk({tag, "_cnt"}, {frame_cnt, err_cnt}, 32'd0);
  endtask

  // Output monitor: pops the scoreboard whenever the DUT produces a result
  always @(negedge clk) begin
    fexp_t       f;
    logic [12:0] el;
    logic [22:0] er;
    if (lct_valid) begin
      if (exp_lct.size() == 0) chk("lct_extra", 32'd1, 32'd0);
      else begin
        el = exp_lct.pop_front();
        chk("lct_word", {19'd0, lct_first, lct_word}, {19'd0, el});
      end
    end
    if (raw_valid) begin
      if (exp_raw.size() == 0) chk("raw_extra", 32'd1, 32'd0);
      else begin
        er = exp_raw.pop_front();
        chk("raw_beat", {9'd0, raw_tbin, raw_layer, raw_wg, raw_data}, {9'd0, er});
      end
    end
    if (frame_done) begin
      if (exp_frm.size() == 0) chk("frame_extra", 32'd1, 32'd0);
      else begin
        f = exp_frm.pop_front();
        if (f.ok) exp_fc++;
        else      exp_ec++;
        $display("[TB] frame bxn=%03h ok=%0d err=%0d", hdr_bxn, frame_ok, err_code);
        chk("frame_ok", 32'(frame_ok), 32'(f.ok));
        chk("err_code", 32'(err_code), 32'(f.err));
        chk("frame_cnt", 32'(frame_cnt), 32'(exp_fc));
        chk("err_cnt", 32'(err_cnt), 32'(exp_ec));
        chk("hdr_bxn", 32'(hdr_bxn), 32'(f.bxn));
      end
    end
  end

  initial begin
    hard_rst = 1'b0;
    daqp     = IDLE_W;
    repeat (3) @(posedge clk);
    #1;
    zero_chk("reset");
    hard_rst = 1'b1;
    gap(3);

    // Minimal frame
    build(12'h001, 0, 0, 0, -1, -1, -1, -1, -1, 0);
    exp_frm.push_back({1'b1, 4'd0, 12'h001});
    send(9999); gap(4);

    // LCT + raw, no suppression
    build(12'h123, 0, 4, 2, -1, -1, -1, -1, -1, 0);
    exp_frm.push_back({1'b1, 4'd0, 12'h123});
    send(9999); gap(4);
    chk("lct_bins", 32'(lct_bins), 32'd4);
    chk("raw_bins", 32'(raw_bins), 32'd2);
    chk("hdr_l1a", 32'(hdr_l1a_cnt), 32'h055);

    // Layer 3 suppressed, time bin 1 cut at layer 2
    build(12'h2A5, 0, 0, 3, 3, 1, 2, -1, -1, 0);
    exp_frm.push_back({1'b1, 4'd0, 12'h2A5});
    send(9999); gap(4);

    // Corrupted LCT word -> CRC error
    build(12'h3C3, 0, 3, 1, -1, -1, -1, 1, -1, 0);
    exp_frm.push_back({1'b0, 4'd5, 12'h3C3});
    send(9999); gap(4);

    // Bad header word 2
    build(12'h404, 0, 0, 1, -1, -1, -1, -1, -1, 1);
    exp_frm.push_back({1'b0, 4'd1, 12'h404});
    send(9999); gap(4);

    // Idle mid-raw aborts the frame, next frame is clean
    build(12'h515, 0, 0, 2, -1, -1, -1, -1, 20, 0);
    exp_frm.push_back({1'b0, 4'd2, 12'h515});
    send(9999); gap(4);
    build(12'h626, 0, 2, 1, -1, -1, -1, -1, -1, 0);
    exp_frm.push_back({1'b1, 4'd0, 12'h626});
    send(9999); gap(4);

    // Config-report frame with a single LCT bin
    build(12'h737, 1, 1, 0, -1, -1, -1, -1, -1, 0);
    exp_frm.push_back({1'b1, 4'd0, 12'h737});
    send(9999); gap(4);

    // Reset mid-CFG drops the frame
    build(12'h848, 1, 0, 0, -1, -1, -1, -1, -1, 0);
    send(48);
    hard_rst = 1'b0;
    daqp     = IDLE_W;
    #2;
    zero_chk("midrst");
    @(posedge clk); #1;
    hard_rst = 1'b1;
    exp_fc = 0;
    exp_ec = 0;
    gap(3);
    build(12'h959, 0, 2, 2, -1, -1, -1, -1, -1, 0);
    exp_frm.push_back({1'b1, 4'd0, 12'h959});
    send(9999); gap(10);

    chk("lct_left", 32'(exp_lct.size()), 32'd0);
    chk("raw_left", 32'(exp_raw.size()), 32'd0);
    chk("frm_left", 32'(exp_frm.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
